// File: rtl/regb_fifo_wr_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package regb_fifo_wr_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  // Upper bound on requesters the pick helper can scan.
  localparam int unsigned MaxReq = 32;

  // Ceiling log2, evaluated at elaboration for owner and counter widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) res = i + 1;
    end
    return res;
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... modulo nreq.
  // Offsets are walked from far to near so the nearest hit wins.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned      ptr,
                                          input int unsigned      nreq);
    int unsigned res;
    int unsigned off;
    int unsigned idx;
    res = 0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      off = MaxReq - 1 - i;
      if (off < nreq) begin
        idx = ptr + off;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regb_fifo_wr_arb_if.sv
// Requester and FIFO write-side signals of the arbiter.
interface regb_fifo_wr_arb_if
  import regb_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
);

  localparam int unsigned OwnW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata_in;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic [OwnW-1:0]       owner;
  logic                  fifo_full;
  logic                  fifo_shift_in;
  logic [WIDTH-1:0]      fifo_wdata;

  // Arbiter side.
  modport master (
    input  req, wdata_in, fifo_full,
    output ack, grant, owner, fifo_shift_in, fifo_wdata
  );

  // Producers plus FIFO side.
  modport slave (
    output req, wdata_in, fifo_full,
    input  ack, grant, owner, fifo_shift_in, fifo_wdata
  );

endinterface

// File: rtl/regb_fifo_wr_arb_rr_arb_pick.sv
// Combinational rotate-priority encoder: first requester at or after ptr_i.
module regb_fifo_wr_arb_rr_arb_pick
  import regb_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [MaxReq-1:0] req_ext;

  // Widen to the helper's fixed scan width, then pick.
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req_i;
    idx_o               = IdxW'(rr_pick(req_ext, 32'(ptr_i), NREQ));
    valid_o             = |req_i;
  end

endmodule

// File: rtl/regb_fifo_wr_arb.sv
// Round-robin write arbiter with bounded bursts in front of a shift FIFO.
module regb_fifo_wr_arb
  import regb_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                res_n,
  regb_fifo_wr_arb_if.master  bus
);

  localparam int unsigned OwnW = clog2(NREQ);
  localparam int unsigned CntW = clog2(MAX_BURST) + 1;
  localparam logic [OwnW-1:0] LastReq = OwnW'(NREQ - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OwnW-1:0] owner_q, owner_d;
  logic [OwnW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic            pick_valid;
  logic [OwnW-1:0] pick_idx;
  logic            in_burst;
  logic            owner_req;
  logic            accept;
  logic [WIDTH-1:0] wsel;

  regb_fifo_wr_arb_rr_arb_pick #(
    .NREQ (NREQ),
    .IdxW (OwnW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Write-side outputs; the reset cycle never issues a write.
  always_comb begin
    in_burst  = (state_q == StBurst);
    owner_req = bus.req[owner_q];
    accept    = in_burst & owner_req & ~bus.fifo_full & res_n;
    wsel      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == OwnW'(i)) wsel = bus.wdata_in[i*WIDTH +: WIDTH];
    end
    bus.fifo_wdata    = in_burst ? wsel : '0;
    bus.fifo_shift_in = accept;
    // grant_q is one-hot on the owner while in a burst.
    bus.ack           = accept ? grant_q : '0;
    bus.grant         = grant_q;
    bus.owner         = owner_q;
  end

  // Grant / burst FSM next state.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d     = StBurst;
          grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      StBurst: begin
        if (!owner_req || (accept && burst_cnt_q == LastCnt)) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (owner_q == LastReq) ? '0 : owner_q + 1'b1;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_regb_fifo_wr_arb.sv
// Directed and random checks for regb_fifo_wr_arb.
module tb_regb_fifo_wr_arb;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  regb_fifo_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  regb_fifo_wr_arb #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Producer model: words still to send and the next word value.
  int               left [NREQ];
  logic [WIDTH-1:0] nxt  [NREQ];
  logic             full_v = 1'b0;

  // Per-cycle traces ('.' none, digit = index) and the FIFO write log.
  string            grant_s;
  string            ack_s;
  int               wr_req[$];
  logic [WIDTH-1:0] wr_dat[$];

  function automatic string idx_char(input logic [NREQ-1:0] v);
    if (v == '0) return ".";
    if ($countones(v) != 1) return "?";
    for (int i = 0; i < int'(NREQ); i++) if (v[i]) return $sformatf("%0d", i);
    return "?";
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req[i] = (left[i] > 0);
      bus.wdata_in[i*WIDTH +: WIDTH] = nxt[i];
    end
    bus.fifo_full = full_v;
  endtask

  task automatic clear_logs();
    grant_s = "";
    ack_s   = "";
    wr_req.delete();
    wr_dat.delete();
  endtask

  // One clock: drive after the edge, observe at the falling edge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      @(negedge clk);
      n_cmp++;
      if (bus.fifo_shift_in === 1'b1 && bus.fifo_full === 1'b1) begin
        n_fail++;
        $display("FAIL shift_while_full: shift_in=%b full=%b, required shift_in=0",
                 bus.fifo_shift_in, bus.fifo_full);
      end
      n_cmp++;
      if (bus.fifo_shift_in !== (|bus.ack) || $countones(bus.ack) > 1) begin
        n_fail++;
        $display("FAIL ack_consistency: ack=%b shift_in=%b, required one-hot ack matching shift_in",
                 bus.ack, bus.fifo_shift_in);
      end
      grant_s = {grant_s, idx_char(bus.grant)};
      ack_s   = {ack_s, idx_char(bus.ack)};
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.ack[i] === 1'b1) begin
          n_cmp++;
          if (bus.fifo_wdata !== nxt[i]) begin
            n_fail++;
            $display("FAIL wdata_req%0d: got %h, required %h", i, bus.fifo_wdata, nxt[i]);
          end
          wr_req.push_back(i);
          wr_dat.push_back(bus.fifo_wdata);
          left[i] = left[i] - 1;
          nxt[i]  = nxt[i] + 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    res_n  = 1'b0;
    full_v = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      left[i] = 0;
      nxt[i]  = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      left[i] = 3;
      nxt[i]  = 4'hA;
    end
    drive();
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.grant !== 4'b0000) begin
      n_fail++; $display("FAIL reset_grant: got %b, required 0000", bus.grant);
    end
    n_cmp++;
    if (bus.ack !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ack: got %b, required 0000", bus.ack);
    end
    n_cmp++;
    if (bus.fifo_shift_in !== 1'b0) begin
      n_fail++; $display("FAIL reset_shift: got %b, required 0", bus.fifo_shift_in);
    end
    n_cmp++;
    if (bus.fifo_wdata !== 4'h0) begin
      n_fail++; $display("FAIL reset_wdata: got %h, required 0", bus.fifo_wdata);
    end
    n_cmp++;
    if (bus.owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_owner: got %0d, required 0", bus.owner);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr_q);
    end
    reset_dut();
  endtask

  task automatic test_single();
    reset_dut();
    left[1] = 10;
    run_cycles(15);
    n_cmp++;
    if (grant_s != ".1111.1111.111.") begin
      n_fail++; $display("FAIL single_grant: got %s, required .1111.1111.111.", grant_s);
    end
    n_cmp++;
    if (ack_s != ".1111.1111.11..") begin
      n_fail++; $display("FAIL single_ack: got %s, required .1111.1111.11..", ack_s);
    end
    n_cmp++;
    if (wr_dat.size() != 10) begin
      n_fail++; $display("FAIL single_count: got %0d words, required 10", wr_dat.size());
    end
    for (int k = 0; k < wr_dat.size(); k++) begin
      n_cmp++;
      if (wr_dat[k] !== WIDTH'(k) || wr_req[k] != 1) begin
        n_fail++;
        $display("FAIL single_order%0d: got req%0d data %h, required req1 data %h",
                 k, wr_req[k], wr_dat[k], WIDTH'(k));
      end
    end
  endtask

  task automatic test_all_four();
    reset_dut();
    for (int i = 0; i < int'(NREQ); i++) begin
      left[i] = 8;
      nxt[i]  = WIDTH'(i * 4);
    end
    run_cycles(25);
    n_cmp++;
    if (grant_s != ".0000.1111.2222.3333.0000") begin
      n_fail++;
      $display("FAIL rr_grant: got %s, required .0000.1111.2222.3333.0000", grant_s);
    end
    n_cmp++;
    if (ack_s != ".0000.1111.2222.3333.0000") begin
      n_fail++;
      $display("FAIL rr_ack: got %s, required .0000.1111.2222.3333.0000", ack_s);
    end
  endtask

  task automatic test_drop();
    reset_dut();
    left[1] = 4;
    left[2] = 2;
    run_cycles(6);
    left[0] = 1;
    left[3] = 1;
    run_cycles(3);
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd3 || bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_release: got rr_ptr=%0d grant=%b, required rr_ptr=3 grant=0000",
               dut.rr_ptr_q, bus.grant);
    end
    run_cycles(7);
    n_cmp++;
    if (grant_s != ".1111.222.33.00.") begin
      n_fail++; $display("FAIL drop_grant: got %s, required .1111.222.33.00.", grant_s);
    end
    n_cmp++;
    if (ack_s != ".1111.22..3..0..") begin
      n_fail++; $display("FAIL drop_ack: got %s, required .1111.22..3..0..", ack_s);
    end
  endtask

  task automatic test_full_stall();
    reset_dut();
    left[0] = 6;
    run_cycles(2);
    full_v = 1'b1;
    run_cycles(3);
    n_cmp++;
    if (dut.burst_cnt_q !== 3'd1 || bus.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_hold: got burst_cnt=%0d grant=%b, required 1 and 0001",
               dut.burst_cnt_q, bus.grant);
    end
    full_v = 1'b0;
    run_cycles(4);
    n_cmp++;
    if (grant_s != ".0000000.") begin
      n_fail++; $display("FAIL stall_grant: got %s, required .0000000.", grant_s);
    end
    n_cmp++;
    if (ack_s != ".0...000.") begin
      n_fail++; $display("FAIL stall_ack: got %s, required .0...000.", ack_s);
    end
    n_cmp++;
    if (wr_dat.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d words, required 4", wr_dat.size());
    end
    for (int k = 0; k < wr_dat.size(); k++) begin
      n_cmp++;
      if (wr_dat[k] !== WIDTH'(k)) begin
        n_fail++; $display("FAIL stall_data%0d: got %h, required %h", k, wr_dat[k], WIDTH'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    left[2] = 6;
    nxt[2]  = 4'h5;
    run_cycles(3);
    n_cmp++;
    if (dut.burst_cnt_q !== 3'd2) begin
      n_fail++; $display("FAIL mid_cnt: got %0d, required 2", dut.burst_cnt_q);
    end
    res_n = 1'b0;
    run_cycles(1);
    n_cmp++;
    if (ack_s != ".22.") begin
      n_fail++; $display("FAIL mid_no_write: got %s, required .22.", ack_s);
    end
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.ack !== 4'b0000 || dut.rr_ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got grant=%b ack=%b rr_ptr=%0d, required 0000 0000 0",
               bus.grant, bus.ack, dut.rr_ptr_q);
    end
    res_n = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) left[i] = 0;
    left[0] = 1;
    left[3] = 1;
    clear_logs();
    run_cycles(5);
    n_cmp++;
    if (grant_s != ".00.3") begin
      n_fail++; $display("FAIL mid_regrant: got %s, required .00.3", grant_s);
    end
    n_cmp++;
    if (ack_s != ".0..3") begin
      n_fail++; $display("FAIL mid_reack: got %s, required .0..3", ack_s);
    end
  endtask

  task automatic test_random();
    int               total [NREQ];
    int               seen  [NREQ];
    logic [WIDTH-1:0] first [NREQ];
    int               busy;
    reset_dut();
    for (int i = 0; i < int'(NREQ); i++) begin
      total[i] = $urandom_range(3, 12);
      left[i]  = total[i];
      nxt[i]   = WIDTH'($urandom_range(0, 15));
      first[i] = nxt[i];
      seen[i]  = 0;
    end
    for (int c = 0; c < 300; c++) begin
      full_v = ($urandom_range(0, 3) == 0);
      run_cycles(1);
    end
    full_v = 1'b0;
    for (int c = 0; c < 200; c++) begin
      busy = 0;
      for (int i = 0; i < int'(NREQ); i++) if (left[i] != 0) busy = 1;
      if (busy != 0) run_cycles(1);
    end
    for (int k = 0; k < wr_dat.size(); k++) begin
      n_cmp++;
      if (wr_dat[k] !== first[wr_req[k]] + WIDTH'(seen[wr_req[k]])) begin
        n_fail++;
        $display("FAIL rand_order%0d: req%0d got %h, required %h", k, wr_req[k], wr_dat[k],
                 first[wr_req[k]] + WIDTH'(seen[wr_req[k]]));
      end
      seen[wr_req[k]]++;
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      n_cmp++;
      if (seen[i] != total[i] || left[i] != 0) begin
        n_fail++;
        $display("FAIL rand_count_req%0d: got %0d writes (%0d left), required %0d",
                 i, seen[i], left[i], total[i]);
      end
    end
  endtask

  initial begin
    bus.req       = '0;
    bus.wdata_in  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_drop();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
